// File: rtl/rx_byte_packer_fifo.sv
// Packs an incoming byte stream into 128-bit words (first byte in [7:0]) and queues them,
// tagged with byte count and last flag, for a 128-bit consumer with 1-cycle read latency.
module rx_byte_packer_fifo #(
  parameter int IN_WIDTH         = 8,
  parameter int OUT_WIDTH        = 128,
  parameter int DEPTH_WIDTH      = 8,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IN_WIDTH-1:0]    wr_data,
  input  logic                   wr_last,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic [DEPTH_WIDTH:0]   wr_water_level,
  input  logic                   rd_en,
  output logic [OUT_WIDTH-1:0]   rd_data,
  output logic [4:0]             rd_bytes,
  output logic                   rd_last,
  output logic                   rd_empty,
  output logic                   almost_empty
);
  localparam int LANES  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int CW     = DEPTH_WIDTH + 1;
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]     AF_CNT    = CW'(ALMOST_FULL_NUM);
  localparam logic [CW-1:0]     AE_CNT    = CW'(ALMOST_EMPTY_NUM);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANES-1:0][IN_WIDTH-1:0] packer;
  logic [LANES-1:0][IN_WIDTH-1:0] packed_word;
  logic [LANE_W-1:0]              lane;
  logic [DEPTH_WIDTH-1:0]         wr_ptr;
  logic [DEPTH_WIDTH-1:0]         rd_ptr;
  logic [CW-1:0]                  count;
  logic [CW-1:0]                  count_nxt;
  logic [4:0]                     commit_bytes;
  logic                           accept;
  logic                           commit;
  logic                           pop;

  // Entry layout: {last, bytes[4:0], data}
  logic [OUT_WIDTH+5:0] mem [DEPTH];

  always_comb begin
    accept       = wr_en & ~wr_full;
    commit       = accept & (wr_last | (lane == LAST_LANE));
    pop          = rd_en & ~rd_empty;
    packed_word  = packer;
    packed_word[lane] = wr_data;
    commit_bytes = 5'(lane) + 5'd1;
    count_nxt    = count;
    case ({commit, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Commit is blocked while full and pop while empty, so the two ports never collide.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem[wr_ptr] <= {wr_last, commit_bytes, packed_word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      packer       <= '0;
      lane         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data      <= '0;
      rd_bytes     <= '0;
      rd_last      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      if (commit) begin
        packer <= '0;
        lane   <= '0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (accept) begin
        packer <= packed_word;
        lane   <= lane + 1'b1;
      end
      if (pop) begin
        {rd_last, rd_bytes, rd_data} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      wr_full      <= (count_nxt == FULL_CNT);
      almost_full  <= (count_nxt >= AF_CNT);
      rd_empty     <= (count_nxt == '0);
      almost_empty <= (count_nxt <= AE_CNT);
    end
  end

  assign wr_water_level = count;

endmodule

// File: tb/tb_rx_byte_packer_fifo.sv
// Directed bench for rx_byte_packer_fifo: packing, tags, flags, full/empty boundaries, reset.
module tb_rx_byte_packer_fifo;
  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         wr_last;
  logic         wr_full;
  logic         almost_full;
  logic [8:0]   wr_water_level;
  logic         rd_en;
  logic [127:0] rd_data;
  logic [4:0]   rd_bytes;
  logic         rd_last;
  logic         rd_empty;
  logic         almost_empty;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [127:0] W0   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W255 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [127:0] W80  = 128'h8F8E8D8C8B8A89888786858483828180;

  rx_byte_packer_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
    .rd_en(rd_en), .rd_data(rd_data), .rd_bytes(rd_bytes), .rd_last(rd_last),
    .rd_empty(rd_empty), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; after settle() the outputs reflect the previous rising edge.
  task automatic settle();
    @(negedge clk);
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rst = 1'b0;
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d; wr_last = l; rd_en = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b1;
    settle();
  endtask

  task automatic put_words(input int first, input int n);
    for (int w = first; w < first + n; w++)
      for (int j = 0; j < 16; j++) put(8'(w * 16 + j), 1'b0);
    settle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    @(negedge clk);
    settle();
    vectors++; if (rd_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", rd_empty); end
    vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
    vectors++; if (wr_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", wr_full); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    vectors++; if (wr_water_level !== 9'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", wr_water_level); end
    vectors++; if ({rd_last, rd_bytes, rd_data} !== 134'd0) begin miscompares++; $display("FAIL reset_rd: got %b %0d %h want 0", rd_last, rd_bytes, rd_data); end
  endtask

  task automatic test_full_word();
    for (int j = 0; j < 16; j++) put(8'(j), 1'b0);
    settle();
    vectors++; if (wr_water_level !== 9'd1 || rd_empty !== 1'b0) begin miscompares++; $display("FAIL t1_level: got %0d empty %b want 1 empty 0", wr_water_level, rd_empty); end
    pop();
    vectors++; if (rd_data !== W0) begin miscompares++; $display("FAIL t1_data: got %h want %h", rd_data, W0); end
    vectors++; if (rd_bytes !== 5'd16 || rd_last !== 1'b0) begin miscompares++; $display("FAIL t1_tags: got %0d/%b want 16/0", rd_bytes, rd_last); end
    vectors++; if (wr_water_level !== 9'd0 || rd_empty !== 1'b1) begin miscompares++; $display("FAIL t1_drain: got %0d empty %b want 0 empty 1", wr_water_level, rd_empty); end
  endtask

  task automatic test_partial();
    put(8'hAA, 1'b0); put(8'hBB, 1'b0); put(8'hCC, 1'b1);
    settle();
    vectors++; if (wr_water_level !== 9'd1) begin miscompares++; $display("FAIL t2_level: got %0d want 1", wr_water_level); end
    pop();
    vectors++; if (rd_data !== 128'h00CCBBAA) begin miscompares++; $display("FAIL t2_data: got %h want %h", rd_data, 128'h00CCBBAA); end
    vectors++; if (rd_bytes !== 5'd3 || rd_last !== 1'b1) begin miscompares++; $display("FAIL t2_tags: got %0d/%b want 3/1", rd_bytes, rd_last); end
  endtask

  task automatic test_full();
    put_words(0, 4);
    vectors++; if (wr_water_level !== 9'd4 || almost_empty !== 1'b1) begin miscompares++; $display("FAIL t3_ae4: got %0d/%b want 4/1", wr_water_level, almost_empty); end
    put_words(4, 1);
    vectors++; if (wr_water_level !== 9'd5 || almost_empty !== 1'b0) begin miscompares++; $display("FAIL t3_ae5: got %0d/%b want 5/0", wr_water_level, almost_empty); end
    put_words(5, 246);
    vectors++; if (wr_water_level !== 9'd251 || almost_full !== 1'b0) begin miscompares++; $display("FAIL t3_af251: got %0d/%b want 251/0", wr_water_level, almost_full); end
    put_words(251, 1);
    vectors++; if (wr_water_level !== 9'd252 || almost_full !== 1'b1) begin miscompares++; $display("FAIL t3_af252: got %0d/%b want 252/1", wr_water_level, almost_full); end
    put_words(252, 3);
    vectors++; if (wr_water_level !== 9'd255 || wr_full !== 1'b0) begin miscompares++; $display("FAIL t3_f255: got %0d/%b want 255/0", wr_water_level, wr_full); end
    put_words(255, 1);
    vectors++; if (wr_water_level !== 9'd256 || wr_full !== 1'b1) begin miscompares++; $display("FAIL t3_f256: got %0d/%b want 256/1", wr_water_level, wr_full); end
    for (int j = 0; j < 16; j++) put(8'hEE, j == 15);
    settle();
    vectors++; if (wr_water_level !== 9'd256 || wr_full !== 1'b1) begin miscompares++; $display("FAIL t3_drop: got %0d/%b want 256/1", wr_water_level, wr_full); end
    pop();
    vectors++; if (rd_data !== W0 || rd_bytes !== 5'd16) begin miscompares++; $display("FAIL t3_pop0: got %h/%0d want %h/16", rd_data, rd_bytes, W0); end
    vectors++; if (wr_water_level !== 9'd255 || wr_full !== 1'b0 || almost_full !== 1'b1) begin miscompares++; $display("FAIL t3_after_pop: got %0d/%b/%b want 255/0/1", wr_water_level, wr_full, almost_full); end
    @(negedge clk);
    rd_en = 1'b1;
    repeat (255) @(negedge clk);
    rd_en = 1'b0;
    vectors++; if (rd_data !== W255 || wr_water_level !== 9'd0 || rd_empty !== 1'b1) begin miscompares++; $display("FAIL t3_drain: got %h/%0d/%b want %h/0/1", rd_data, wr_water_level, rd_empty, W255); end
  endtask

  task automatic test_back_to_back();
    put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b1);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h44; wr_last = 1'b1; rd_en = 1'b1;
    settle();
    vectors++; if (wr_water_level !== 9'd1 || rd_empty !== 1'b0) begin miscompares++; $display("FAIL t4_level: got %0d/%b want 1/0", wr_water_level, rd_empty); end
    vectors++; if (rd_data !== 128'h332211 || rd_bytes !== 5'd3 || rd_last !== 1'b1) begin miscompares++; $display("FAIL t4_pop1: got %h/%0d/%b want 332211/3/1", rd_data, rd_bytes, rd_last); end
    pop();
    vectors++; if (rd_data !== 128'h44 || rd_bytes !== 5'd1 || wr_water_level !== 9'd0) begin miscompares++; $display("FAIL t4_pop2: got %h/%0d/%0d want 44/1/0", rd_data, rd_bytes, wr_water_level); end
    for (int j = 0; j < 16; j++) put(8'(8'h50 + j), 1'b0);
    put(8'h99, 1'b1);
    settle();
    vectors++; if (wr_water_level !== 9'd2) begin miscompares++; $display("FAIL t4_nobubble: got %0d want 2", wr_water_level); end
    pop(); pop();
    vectors++; if (rd_data !== 128'h99 || rd_bytes !== 5'd1 || rd_last !== 1'b1) begin miscompares++; $display("FAIL t4_pop4: got %h/%0d/%b want 99/1/1", rd_data, rd_bytes, rd_last); end
  endtask

  task automatic test_reset_mid();
    put_words(0, 1);
    for (int j = 0; j < 7; j++) put(8'h77, 1'b0);
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
    settle();
    vectors++; if (wr_water_level !== 9'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1) begin miscompares++; $display("FAIL t5_flags: got %0d/%b/%b want 0/1/1", wr_water_level, rd_empty, almost_empty); end
    vectors++; if ({rd_last, rd_bytes, rd_data} !== 134'd0) begin miscompares++; $display("FAIL t5_rd: got %b/%0d/%h want 0", rd_last, rd_bytes, rd_data); end
    for (int j = 0; j < 16; j++) put(8'(8'h80 + j), 1'b0);
    settle();
    pop();
    vectors++; if (rd_data !== W80 || rd_bytes !== 5'd16 || rd_last !== 1'b0) begin miscompares++; $display("FAIL t5_clean: got %h/%0d/%b want %h/16/0", rd_data, rd_bytes, rd_last, W80); end
  endtask

  task automatic test_idle();
    @(negedge clk);
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    vectors++; if (rd_data !== W80 || rd_bytes !== 5'd16 || wr_water_level !== 9'd0 || rd_empty !== 1'b1) begin miscompares++; $display("FAIL t6_rd_empty: got %h/%0d/%0d/%b want hold, level 0", rd_data, rd_bytes, wr_water_level, rd_empty); end
    @(negedge clk);
    wr_en = 1'b0; wr_last = 1'b1; wr_data = 8'h5A;
    repeat (2) @(negedge clk);
    wr_last = 1'b0;
    vectors++; if (wr_water_level !== 9'd0 || rd_empty !== 1'b1) begin miscompares++; $display("FAIL t6_last_alone: got %0d/%b want 0/1", wr_water_level, rd_empty); end
    put(8'h01, 1'b0); put(8'h02, 1'b1);
    settle();
    pop();
    vectors++; if (rd_data !== 128'h0201 || rd_bytes !== 5'd2 || rd_last !== 1'b1) begin miscompares++; $display("FAIL t6_after: got %h/%0d/%b want 0201/2/1", rd_data, rd_bytes, rd_last); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; rd_en = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
